// File: rtl/seq_pkg.sv
// Shared encodings for the 10110 sequence link: FSM states and the sync pattern.
// Used by both the stream transmitter and the sequence detector.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PRE   = 2'b01,
        ST_SHIFT = 2'b10
    } seq_state_e;

    localparam logic [4:0] SEQ_PATTERN_10110 = 5'b10110;
    localparam int         SEQ_PATTERN_LEN   = 5;

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, shift-left register; msb presents the next bit to transmit.
// Load has priority over shift.
module seq_piso #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            sr_d = {sr_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/seq_stream_tx.sv
// Serial MSB-first transmitter for the 10110 sequence-detect link, valid/ready input.
// Define SYNC_PREAMBLE_EN to prefix every frame with the PRE_PAT sync preamble.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no frame in flight, out=0, ready for a word
// ST_PRE   | sending the sync preamble (SYNC_PREAMBLE_EN builds only)
// ST_SHIFT | sending data bits; remaining==0 marks the last bit on out
module seq_stream_tx
    import seq_pkg::*;
#(
    parameter int                 WIDTH   = 16,
    parameter int                 PRE_LEN = SEQ_PATTERN_LEN,
    parameter logic [PRE_LEN-1:0] PRE_PAT = SEQ_PATTERN_10110
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out,
    output logic             out_valid,
    output logic [1:0]       state
);

    localparam int CNT_W = $clog2(WIDTH);
    typedef logic [CNT_W-1:0] cnt_t;

`ifdef SYNC_PREAMBLE_EN
    localparam seq_state_e       ST_START = ST_PRE;
    localparam logic [WIDTH-1:0] PRE_WIDE = WIDTH'(PRE_PAT);
    cnt_t pre_idx;
`else
    localparam seq_state_e ST_START = ST_SHIFT;
    logic [PRE_LEN-1:0] pre_unused;
    assign pre_unused = PRE_PAT;
`endif

    seq_state_e       state_q, state_d;
    logic             out_q, out_d;
    logic             out_valid_q, out_valid_d;
    cnt_t             rem_q, rem_d;
    logic             last_bit;
    logic             accept;
    logic             piso_load;
    logic             piso_shift;
    logic             piso_msb;
    logic [WIDTH-1:0] piso_din;

    assign last_bit = (state_q == ST_SHIFT) && (rem_q == '0);
    assign accept   = in_valid && in_ready;

    // Without a preamble the MSB goes straight to out, so the PISO holds only the tail.
`ifdef SYNC_PREAMBLE_EN
    assign piso_din = in_data;
    assign pre_idx  = rem_q - 1'b1;
`else
    assign piso_din = {in_data[WIDTH-2:0], 1'b0};
`endif

    seq_piso #(.WIDTH(WIDTH)) u_piso (
        .clk   (clk),
        .rst_n (reset),
        .load  (piso_load),
        .shift (piso_shift),
        .din   (piso_din),
        .msb   (piso_msb)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            rem_q       <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_START;
            end
            ST_PRE: begin
                if (rem_q == '0) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last_bit) state_d = accept ? ST_START : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state_q == ST_IDLE) || last_bit;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        rem_d       = rem_q;
        piso_load   = 1'b0;
        piso_shift  = 1'b0;
        if (accept) begin
            piso_load   = 1'b1;
            out_valid_d = 1'b1;
`ifdef SYNC_PREAMBLE_EN
            out_d       = PRE_WIDE[PRE_LEN-1];
            rem_d       = cnt_t'(PRE_LEN - 1);
`else
            out_d       = in_data[WIDTH-1];
            rem_d       = cnt_t'(WIDTH - 1);
`endif
        end else begin
            case (state_q)
`ifdef SYNC_PREAMBLE_EN
                ST_PRE: begin
                    if (rem_q != '0) begin
                        out_d = PRE_WIDE[pre_idx];
                        rem_d = pre_idx;
                    end else begin
                        out_d      = piso_msb;
                        piso_shift = 1'b1;
                        rem_d      = cnt_t'(WIDTH - 1);
                    end
                end
`endif
                ST_SHIFT: begin
                    if (rem_q != '0) begin
                        out_d      = piso_msb;
                        piso_shift = 1'b1;
                        rem_d      = rem_q - 1'b1;
                    end else begin
                        out_d       = 1'b0;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    out_d       = 1'b0;
                    out_valid_d = 1'b0;
                    rem_d       = '0;
                end
            endcase
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign state     = state_q;

endmodule
